// File: rtl/alu_axil_slave_if.sv
// AXI4-Lite bus bundle between the AXI VIP master and the ALU register
// front-end. Carries the five AXI4-Lite channels; clock and reset stay
// outside as plain module ports.
//   slave modport : used by alu_axil_slave
//   master modport: used by the driving master (VIP or testbench)
interface alu_axil_slave_if #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) ();
    // write address channel
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]                      S_AXI_AWPROT;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    // write data channel
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    // write response channel
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    // read address channel
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]                      S_AXI_ARPROT;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    // read data channel
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/alu_axil_slave.sv
// AXI4-Lite register front-end for the ALU core.
// Register map (word index = addr[4:2]):
//   0x00 OPA rw, 0x04 OPB rw, 0x08 CTRL rw ([3:0] opcode, [31] start, reads 0),
//   0x0C USER rw, 0x10 RESULT ro, 0x14 STATUS ro
//   ({start_err, busy, done, ovf, carry, zero}), 0x18/0x1C read 0.
// Ports:
//   ACLK, ARESET        clock, synchronous active-high reset
//   s_axi               AXI4-Lite slave bus (always OKAY responses)
//   alu_op_a/op_b       operand registers to the core
//   alu_opcode          CTRL[3:0]
//   alu_start           one-cycle start pulse, cycle after the CTRL commit
//   alu_result/flags    core result and {ovf,carry,zero}, captured on alu_done
//   alu_done            one-cycle completion pulse from the core
module alu_axil_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    alu_axil_slave_if.slave      s_axi,
    output logic [31:0]          alu_op_a,
    output logic [31:0]          alu_op_b,
    output logic [3:0]           alu_opcode,
    output logic                 alu_start,
    input  logic [31:0]          alu_result,
    input  logic [2:0]           alu_flags,
    input  logic                 alu_done
);

    typedef enum logic [2:0] {
        REG_OPA    = 3'd0,
        REG_OPB    = 3'd1,
        REG_CTRL   = 3'd2,
        REG_USER   = 3'd3,
        REG_RESULT = 3'd4,
        REG_STATUS = 3'd5,
        REG_RSVD6  = 3'd6,
        REG_RSVD7  = 3'd7
    } reg_idx_t;

    // Out-of-reset flag: keeps every ready low during reset and lets them
    // rise on the first edge with ARESET deasserted.
    logic        ready_en;

    // write holding buffers
    logic        aw_full;
    reg_idx_t    aw_idx_q;
    logic        w_full;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;

    logic        bvalid;
    logic        rvalid;
    logic [31:0] rdata;

    // register file
    logic [31:0] opa, opb, user, result;
    logic [3:0]  opcode;
    logic [2:0]  flags;
    logic        done, busy, start_err;
    logic        start_pulse;

    logic        awready, wready, arready;
    logic        aw_hs, w_hs, ar_hs, commit;
    reg_idx_t    wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        start_req, start_ok;
    logic [31:0] status_word, rd_word;

    logic        unused_bits;
    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    always_comb begin
        awready = ready_en & ~aw_full & ~bvalid;
        wready  = ready_en & ~w_full  & ~bvalid;
        arready = ready_en & ~rvalid;
        aw_hs   = s_axi.S_AXI_AWVALID & awready;
        w_hs    = s_axi.S_AXI_WVALID  & wready;
        ar_hs   = s_axi.S_AXI_ARVALID & arready;

        // A commit may combine a buffered half with the half arriving now.
        wr_idx  = aw_full ? aw_idx_q : reg_idx_t'(s_axi.S_AXI_AWADDR[4:2]);
        wr_data = w_full  ? w_data_q : s_axi.S_AXI_WDATA;
        wr_strb = w_full  ? w_strb_q : s_axi.S_AXI_WSTRB;
        commit  = (aw_full | aw_hs) & (w_full | w_hs);

        start_req = commit & (wr_idx == REG_CTRL) & wr_strb[3] & wr_data[31];
        start_ok  = start_req & ~busy;

        status_word = {26'd0, start_err, busy, done, flags};

        rd_word = '0;
        case (reg_idx_t'(s_axi.S_AXI_ARADDR[4:2]))
            REG_OPA:    rd_word = opa;
            REG_OPB:    rd_word = opb;
            REG_CTRL:   rd_word = {28'd0, opcode};
            REG_USER:   rd_word = user;
            REG_RESULT: rd_word = result;
            REG_STATUS: rd_word = status_word;
            default:    rd_word = '0;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ready_en    <= 1'b0;
            aw_full     <= 1'b0;
            aw_idx_q    <= REG_OPA;
            w_full      <= 1'b0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            bvalid      <= 1'b0;
            rvalid      <= 1'b0;
            rdata       <= '0;
            opa         <= '0;
            opb         <= '0;
            user        <= '0;
            result      <= '0;
            opcode      <= '0;
            flags       <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            start_err   <= 1'b0;
            start_pulse <= 1'b0;
        end else begin
            ready_en <= 1'b1;

            if (aw_hs) begin
                aw_full  <= 1'b1;
                aw_idx_q <= reg_idx_t'(s_axi.S_AXI_AWADDR[4:2]);
            end
            if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= s_axi.S_AXI_WDATA;
                w_strb_q <= s_axi.S_AXI_WSTRB;
            end

            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bvalid  <= 1'b1;
                case (wr_idx)
                    REG_OPA:  opa  <= merge_bytes(opa, wr_data, wr_strb);
                    REG_OPB:  opb  <= merge_bytes(opb, wr_data, wr_strb);
                    REG_USER: user <= merge_bytes(user, wr_data, wr_strb);
                    REG_CTRL: if (wr_strb[0]) opcode <= wr_data[3:0];
                    default:  ;
                endcase
            end else if (bvalid && s_axi.S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end

            // rdata samples the registers before this edge's write lands.
            if (ar_hs) begin
                rvalid <= 1'b1;
                rdata  <= rd_word;
            end else if (rvalid && s_axi.S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end

            start_pulse <= start_ok;

            // Completion capture first; an accepted start in the same cycle
            // then overrides busy/done below.
            if (alu_done) begin
                result <= alu_result;
                flags  <= alu_flags;
                done   <= 1'b1;
                busy   <= 1'b0;
            end
            if (start_ok) begin
                busy      <= 1'b1;
                done      <= 1'b0;
                start_err <= 1'b0;
            end else if (start_req) begin
                start_err <= 1'b1;
            end
        end
    end

    assign s_axi.S_AXI_AWREADY = awready;
    assign s_axi.S_AXI_WREADY  = wready;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_BVALID  = bvalid;
    assign s_axi.S_AXI_ARREADY = arready;
    assign s_axi.S_AXI_RDATA   = rdata;
    assign s_axi.S_AXI_RRESP   = 2'b00;
    assign s_axi.S_AXI_RVALID  = rvalid;

    assign alu_op_a   = opa;
    assign alu_op_b   = opb;
    assign alu_opcode = opcode;
    assign alu_start  = start_pulse;

endmodule

// File: tb/tb_alu_axil_slave.sv
// Directed testbench for alu_axil_slave: table-driven register access plus
// hand-written sequences for strobes, start/done, start-while-busy,
// split AW/W with write back-pressure, and reset during an in-flight write.
module tb_alu_axil_slave;

    logic clk = 1'b0;
    logic areset = 1'b1;
    always #5 clk = ~clk;

    alu_axil_slave_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) axi ();

    logic [31:0] alu_op_a, alu_op_b, alu_result;
    logic [3:0]  alu_opcode;
    logic        alu_start, alu_done;
    logic [2:0]  alu_flags;

    alu_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
        .ACLK       (clk),
        .ARESET     (areset),
        .s_axi      (axi),
        .alu_op_a   (alu_op_a),
        .alu_op_b   (alu_op_b),
        .alu_opcode (alu_opcode),
        .alu_start  (alu_start),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .alu_done   (alu_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // event monitor, sampled at the active edge before the DUT updates
    int   cyc = 0, start_cnt = 0, start_cyc = -1, bv_rise_cyc = -2;
    int   b_hs = 0, r_hs = 0, exp_b = 0, exp_r = 0;
    logic bv_q = 1'b0;
    always @(posedge clk) begin
        cyc++;
        if (alu_start === 1'b1) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (axi.S_AXI_BVALID === 1'b1 && bv_q !== 1'b1) bv_rise_cyc = cyc;
        bv_q = axi.S_AXI_BVALID;
        if (axi.S_AXI_BVALID === 1'b1 && axi.S_AXI_BREADY === 1'b1) b_hs++;
        if (axi.S_AXI_RVALID === 1'b1 && axi.S_AXI_RREADY === 1'b1) r_hs++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit aw_d = 0;
        bit w_d = 0;
        int n = 0;
        @(negedge clk);
        axi.S_AXI_AWADDR  = addr;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WDATA   = data;
        axi.S_AXI_WSTRB   = strb;
        axi.S_AXI_WVALID  = 1'b1;
        while (!(aw_d && w_d) && n < 50) begin
            if (axi.S_AXI_AWVALID && axi.S_AXI_AWREADY) aw_d = 1;
            if (axi.S_AXI_WVALID && axi.S_AXI_WREADY) w_d = 1;
            @(negedge clk);
            n++;
            if (aw_d) axi.S_AXI_AWVALID = 1'b0;
            if (w_d)  axi.S_AXI_WVALID  = 1'b0;
        end
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        check("wr_accept", {31'd0, aw_d & w_d}, 32'd1);
        axi.S_AXI_BREADY = 1'b1;
        n = 0;
        while (axi.S_AXI_BVALID !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bvalid_seen", {31'd0, axi.S_AXI_BVALID}, 32'd1);
        check("bresp", {30'd0, axi.S_AXI_BRESP}, 32'd0);
        exp_b++;
        @(negedge clk);
        axi.S_AXI_BREADY = 1'b0;
    endtask

    // RREADY is randomised while the response is pending; RDATA must stay put.
    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
        int n = 0;
        bit seen = 0, stable = 1, got = 0;
        logic [31:0] first;
        first = '0;
        @(negedge clk);
        axi.S_AXI_ARADDR  = addr;
        axi.S_AXI_ARVALID = 1'b1;
        axi.S_AXI_RREADY  = 1'($urandom_range(0, 1));
        while (axi.S_AXI_ARREADY !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ar_accept", {31'd0, axi.S_AXI_ARREADY}, 32'd1);
        @(negedge clk);
        axi.S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!got && n < 50) begin
            if (axi.S_AXI_RVALID === 1'b1) begin
                if (!seen) begin
                    first = axi.S_AXI_RDATA;
                    seen = 1;
                end else if (axi.S_AXI_RDATA !== first) begin
                    stable = 0;
                end
                if (axi.S_AXI_RREADY) got = 1;
            end
            if (!got) begin
                @(negedge clk);
                n++;
                axi.S_AXI_RREADY = 1'($urandom_range(0, 1));
            end
        end
        check("r_delivered", {31'd0, got}, 32'd1);
        check("rdata_stable", {31'd0, stable}, 32'd1);
        check("rresp", {30'd0, axi.S_AXI_RRESP}, 32'd0);
        data = first;
        exp_r++;
        @(negedge clk);
        axi.S_AXI_RREADY = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [31:0] rd;
        int s0;
        int ok_cnt;

        vecs[0] = '{5'h00, 32'h0000_0001, 4'hF, 32'h0000_0001};
        vecs[1] = '{5'h04, 32'h0000_0002, 4'hF, 32'h0000_0002};
        vecs[2] = '{5'h08, 32'h0000_0003, 4'hF, 32'h0000_0003};
        vecs[3] = '{5'h0C, 32'h0000_0004, 4'hF, 32'h0000_0004};
        vecs[4] = '{5'h10, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
        vecs[5] = '{5'h14, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
        vecs[6] = '{5'h18, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
        vecs[7] = '{5'h1C, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};

        axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WDATA  = '0; axi.S_AXI_WSTRB  = '0; axi.S_AXI_WVALID  = 1'b0;
        axi.S_AXI_BREADY = 1'b0;
        axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0; axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_RREADY = 1'b0;
        alu_result = '0; alu_flags = '0; alu_done = 1'b0;

        // reset: readies low while held, high one edge after release
        repeat (3) @(negedge clk);
        check("rst_readies_low", {29'd0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 32'd0);
        repeat (7) @(negedge clk);
        check("rst_valids_low", {29'd0, axi.S_AXI_BVALID, axi.S_AXI_RVALID, alu_start}, 32'd0);
        areset = 1'b0;
        @(negedge clk);
        check("post_rst_readies", {29'd0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 32'd7);
        check("post_rst_valids", {29'd0, axi.S_AXI_BVALID, axi.S_AXI_RVALID, alu_start}, 32'd0);
        check("post_rst_op_a", alu_op_a, 32'd0);

        // table: write all, then read all back
        for (int i = 0; i < 8; i++) axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
        for (int i = 0; i < 8; i++) begin
            axi_read(vecs[i].addr, rd);
            check($sformatf("reg_rd_%02h", vecs[i].addr), rd, vecs[i].exp);
        end
        check("alu_opcode", {28'd0, alu_opcode}, 32'd3);
        check("no_start_seen", start_cnt, 32'd0);
        axi_read(5'h0F, rd);
        check("addr_lsb_ignored", rd, 32'd4);

        // byte strobes
        axi_write(5'h00, 32'hAABB_CCDD, 4'hF);
        axi_write(5'h00, 32'h1122_3344, 4'b0101);
        axi_read(5'h00, rd);
        check("strobe_opa", rd, 32'hAA22_CC44);
        check("strobe_alu_op_a", alu_op_a, 32'hAA22_CC44);

        // start / done
        s0 = start_cnt;
        axi_write(5'h08, 32'h8000_0002, 4'hF);
        repeat (2) @(negedge clk);
        check("start_pulses", start_cnt - s0, 32'd1);
        check("start_with_bvalid", start_cyc, bv_rise_cyc);
        axi_read(5'h14, rd);
        check("status_busy", rd, 32'h10);
        axi_read(5'h08, rd);
        check("ctrl_bit31_reads0", rd, 32'h2);
        check("alu_opcode_2", {28'd0, alu_opcode}, 32'd2);

        @(negedge clk);
        alu_result = 32'hDEAD_BEEF; alu_flags = 3'b010; alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
        axi_read(5'h10, rd);
        check("result", rd, 32'hDEAD_BEEF);
        axi_read(5'h14, rd);
        check("status_done", rd, 32'h0A);

        // start while busy
        s0 = start_cnt;
        axi_write(5'h08, 32'h8000_0001, 4'hF);
        axi_read(5'h14, rd);
        check("status_busy2", rd, 32'h12);
        axi_write(5'h08, 32'h8000_0001, 4'hF);
        repeat (2) @(negedge clk);
        check("busy_start_no_pulse", start_cnt - s0, 32'd1);
        axi_read(5'h14, rd);
        check("status_start_err", rd, 32'h32);

        @(negedge clk);
        alu_result = 32'h1234_5678; alu_flags = 3'b101; alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
        axi_read(5'h14, rd);
        check("status_err_sticky", rd, 32'h2D);
        axi_read(5'h10, rd);
        check("result2", rd, 32'h1234_5678);

        s0 = start_cnt;
        axi_write(5'h08, 32'h8000_0001, 4'hF);
        axi_read(5'h14, rd);
        check("start_clears_err", rd, 32'h15);
        // start bit without lane 3 strobe is not a start request
        axi_write(5'h08, 32'h8000_0004, 4'b0111);
        repeat (2) @(negedge clk);
        check("strb3_gates_start", start_cnt - s0, 32'd1);
        axi_read(5'h14, rd);
        check("status_no_err", rd, 32'h15);
        check("opcode_lane0", {28'd0, alu_opcode}, 32'd4);

        // split W before AW, BREADY held low 5 cycles
        @(negedge clk);
        axi.S_AXI_WDATA = 32'h55AA_55AA; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
        @(negedge clk);
        axi.S_AXI_WVALID = 1'b0;
        ok_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (axi.S_AXI_WREADY === 1'b0 && axi.S_AXI_AWREADY === 1'b1 && axi.S_AXI_BVALID === 1'b0)
                ok_cnt++;
            @(negedge clk);
        end
        check("w_held_no_commit", ok_cnt, 32'd3);
        check("opb_unchanged", alu_op_b, 32'd2);
        axi.S_AXI_AWADDR = 5'h04; axi.S_AXI_AWVALID = 1'b1;
        @(negedge clk);
        axi.S_AXI_AWVALID = 1'b0;
        check("commit_on_aw", alu_op_b, 32'h55AA_55AA);
        ok_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (axi.S_AXI_BVALID === 1'b1 && axi.S_AXI_AWREADY === 1'b0 && axi.S_AXI_WREADY === 1'b0)
                ok_cnt++;
            @(negedge clk);
        end
        check("bvalid_held_blocked", ok_cnt, 32'd5);
        axi.S_AXI_BREADY = 1'b1;
        exp_b++;
        @(negedge clk);
        axi.S_AXI_BREADY = 1'b0;
        check("bvalid_dropped", {31'd0, axi.S_AXI_BVALID}, 32'd0);
        axi_read(5'h04, rd);
        check("split_readback", rd, 32'h55AA_55AA);

        // reset while a W half sits in its buffer: it must be dropped
        @(negedge clk);
        axi.S_AXI_WDATA = 32'h0000_0077; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
        @(negedge clk);
        axi.S_AXI_WVALID = 1'b0;
        areset = 1'b1;
        repeat (2) @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        check("wready_after_rst", {31'd0, axi.S_AXI_WREADY}, 32'd1);
        axi_write(5'h0C, 32'h0000_0099, 4'hF);
        axi_read(5'h0C, rd);
        check("user_after_rst", rd, 32'h99);
        axi_read(5'h04, rd);
        check("opb_cleared", rd, 32'h0);

        repeat (2) @(negedge clk);
        check("b_responses_once", b_hs, exp_b);
        check("r_responses_once", r_hs, exp_r);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_axil_slave.md
# alu_axil_slave

AXI4-Lite slave register front-end for the ALU IP. It sits directly downstream of the AXI VIP master in the block design and upstream of the ALU datapath core. It decodes AXI4-Lite reads and writes into four read/write configuration registers and two read-only result/status registers. It also issues a one-cycle start pulse to the ALU core and captures the core's result when the core signals completion.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; decodes 0x00–0x1C.
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- S_AXI_AWADDR/AWPROT/AWVALID  in  5/3/1; S_AXI_AWREADY  out  1  write address channel (AWPROT ignored).
- S_AXI_WDATA/WSTRB/WVALID  in  32/4/1; S_AXI_WREADY  out  1  write data channel.
- S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1  write response channel.
- S_AXI_ARADDR/ARPROT/ARVALID  in  5/3/1; S_AXI_ARREADY  out  1  read address channel.
- S_AXI_RDATA  out  32; S_AXI_RRESP  out  2; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1  read data channel.
- alu_op_a, alu_op_b  out  32  operand registers to the ALU core.
- alu_opcode  out  4  CTRL[3:0].
- alu_start  out  1  one-cycle start pulse.
- alu_result  in  32; alu_flags  in  3 {ovf,carry,zero}; alu_done  in  1  one-cycle completion pulse.

## Operation
- Register map (word index is addr[4:2]; addr[1:0] ignored):
  - 0x00 OPA rw
  - 0x04 OPB rw
  - 0x08 CTRL rw: [3:0] opcode; [31] start, write-only, reads 0
  - 0x0C USER rw scratch
  - 0x10 RESULT ro
  - 0x14 STATUS ro: [0] zero, [1] carry, [2] ovf, [3] done, [4] busy, [5] start_err
  - 0x18/0x1C read 0, writes ignored
- All responses are OKAY (2'b00). Writes to read-only or unused addresses complete normally with no effect.
- WSTRB: byte lane n is updated only when WSTRB[n]=1. The CTRL start bit requires WSTRB[3]=1.
- Write path: AW and W are each latched into a one-entry holding buffer, independently and in either order.
  - AWREADY = AW buffer empty and no BVALID pending; WREADY is the same with the W buffer.
  - When both buffers are full, the write commits on that edge, both buffers clear, and BVALID rises next cycle.
  - BVALID holds until BREADY.
- Read path: ARREADY = !RVALID.
  - On an AR handshake, RDATA is registered and RVALID rises next cycle.
  - RDATA and RVALID hold stable until RREADY.
- Start:
  - A CTRL write with bit31=1 while busy=0 pulses alu_start for exactly one cycle, starting the cycle after commit. It also sets busy and clears done and start_err.
  - A start while busy=1 produces no pulse and sets start_err (sticky until the next accepted start).
- Completion: alu_done=1 loads RESULT←alu_result and STATUS[2:0]←alu_flags, sets done, and clears busy.
- Simultaneous events:
  - alu_done in the same cycle as an accepted start: done capture happens first, then the start sets busy and clears done. Net: busy=1, done=0, RESULT updated.
  - Read and write to the same register in the same cycle: the read returns the pre-write value.
  - alu_done while busy=0 is still captured (RESULT/flags updated, done set).
- alu_op_a, alu_op_b and alu_opcode continuously reflect OPA, OPB and CTRL[3:0].

## Timing
- Reset (ARESET=1 at an edge):
  - All registers and outputs go to 0, including AWREADY, WREADY, ARREADY, BVALID, RVALID and alu_start.
  - Both buffers are emptied; an in-flight transaction is dropped with no response.
  - Ready signals rise on the first edge with ARESET=0.
- Write latency:
  - AW+W handshake in the same cycle T: register updated at end of T; BVALID at T+1; alu_start (if any) at T+1.
  - Split AW/W: commit at the edge where the second one is accepted.
- With BREADY held at 1: BVALID lasts one cycle, and the next write can handshake at T+2. Sustained throughput is one write per 2 cycles.
- Read latency: one cycle from the AR handshake to RVALID. With RREADY=1, throughput is one read per 2 cycles.
- Back-pressure: while BVALID=1 and BREADY=0, AWREADY and WREADY stay 0 once the buffers fill. No transaction is lost.
- Read and write paths are fully independent; no mutual stalling.

## Test plan
- Reset check: hold ARESET 10 cycles, release → all ready outputs 0 during reset, then 1 one cycle later; BVALID=RVALID=alu_start=0.
- Sequential register access:
  - Write 0x1, 0x2, 0x3, 0x4 to 0x00, 0x04, 0x08, 0x0C.
  - Read back → 0x1, 0x2, 0x3, 0x4, all RRESP=OKAY.
  - alu_opcode=0x3, and CTRL reads bit31=0.
- Byte strobes: write 0xAABBCCDD to OPA, then write 0x11223344 with WSTRB=4'b0101 → OPA reads 0xAA22CC44.
- Start/done:
  - Write CTRL=0x80000002 → alu_start pulses 1 cycle; STATUS=0x10.
  - Drive alu_done with alu_result=0xDEADBEEF, flags=3'b010 → RESULT=0xDEADBEEF, STATUS=0x0A.
- Start while busy: issue a second start before alu_done → no alu_start pulse; STATUS[5]=1, busy stays 1.
- Handshake stress:
  - Send W three cycles before AW; hold BREADY=0 for 5 cycles; randomize RREADY.
  - Expected: write commits when AW arrives; BVALID held 5 cycles; AWREADY=WREADY=0 while blocked; every response is delivered exactly once.
